// File: rtl/pwm_fade_controller.sv
// ---------------------------------------------------------------------------
// pwm_fade_controller
//
// Sequences the duty code of a downstream PWM driver. The code moves from
// its present value toward a requested target in fixed steps, one step per
// slow tick. The final value is then held for HOLD_TICKS ticks, and `done`
// pulses once the fade is complete.
//
// Optional feature: define PWM_FADE_BREATHE_EN to add the `breathe` input.
// While `breathe` is high and no request is offered, the block fades on its
// own, alternating between full scale and zero with step 1. These
// self-issued fades never pulse `done`.
//
// Handshake: a request transfers on a rising clk edge when req_valid and
// req_ready are both high. req_ready is high only in IDLE while reset is
// released. The requester holds req_target and req_step stable until the
// transfer. Any req_valid seen outside IDLE is dropped, with no queueing.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-low reset
//   req_valid   request fields are valid
//   req_ready   block can accept a request
//   req_target  target duty code (RES bits)
//   req_step    step per tick (RES bits, 0 treated as 1)
//   breathe     auto-fade enable (only with PWM_FADE_BREATHE_EN)
//   duty        registered duty code, connects to the driver's in_value
//   busy        high in RAMP and HOLD
//   done        one-cycle pulse after a requested fade completes
//   state_dbg   current FSM state (IDLE=0, RAMP=1, HOLD=2)
// ---------------------------------------------------------------------------
module pwm_fade_controller #(
    parameter int RES        = 3,
    parameter int TICK_DIV   = 83333,
    parameter int HOLD_TICKS = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [RES-1:0] req_target,
    input  logic [RES-1:0] req_step,
`ifdef PWM_FADE_BREATHE_EN
    input  logic           breathe,
`endif
    output logic [RES-1:0] duty,
    output logic           busy,
    output logic           done,
    output logic [1:0]     state_dbg
);

    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [RES-1:0]    STEP_ONE  = RES'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  tick_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [RES-1:0]    target_q;
    logic [RES-1:0]    step_q;
    logic [RES:0]      diff;
    logic              tick;
    logic              reach;
    logic              hold_last;
    logic              start_ext;
    logic              start;
`ifdef PWM_FADE_BREATHE_EN
    logic              start_auto;
    logic              self_q;      // current fade was self-issued
`endif

    // ------------------------------------------------------------------
    // Next-state and decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        tick       = (state != IDLE) && (tick_cnt == TICK_LAST);
        // The extra bit keeps the distance exact across the full code range.
        if (target_q >= duty) begin
            diff = {1'b0, target_q} - {1'b0, duty};
        end else begin
            diff = {1'b0, duty} - {1'b0, target_q};
        end
        reach      = (diff <= {1'b0, step_q});
        hold_last  = (hold_cnt == HOLD_LAST);
        start_ext  = (state == IDLE) && req_valid;
`ifdef PWM_FADE_BREATHE_EN
        // An external request always wins over the self-issued fade.
        start_auto = (state == IDLE) && !req_valid && breathe;
        start      = start_ext || start_auto;
`else
        start      = start_ext;
`endif

        case (state)
            IDLE: if (start) state_next = RAMP;
            RAMP: if (tick && reach) state_next = HOLD;
            HOLD: if (tick && hold_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: latched request, tick/hold counters, duty, done
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt <= '0;
            hold_cnt <= '0;
            target_q <= '0;
            step_q   <= '0;
            duty     <= '0;
            done     <= 1'b0;
`ifdef PWM_FADE_BREATHE_EN
            self_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ext) begin
                        target_q <= req_target;
                        step_q   <= (req_step == '0) ? STEP_ONE : req_step;
                        tick_cnt <= '0;
`ifdef PWM_FADE_BREATHE_EN
                        self_q   <= 1'b0;
                    end else if (start_auto) begin
                        // Below half scale fade up to full, otherwise fade down to 0.
                        target_q <= duty[RES-1] ? '0 : '1;
                        step_q   <= STEP_ONE;
                        tick_cnt <= '0;
                        self_q   <= 1'b1;
`endif
                    end
                end
                RAMP: begin
                    tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
                    if (tick) begin
                        if (reach) begin
                            // Final step is clamped onto the target, so there is no overshoot.
                            duty     <= target_q;
                            hold_cnt <= '0;
                        end else if (target_q > duty) begin
                            duty <= duty + step_q;
                        end else begin
                            duty <= duty - step_q;
                        end
                    end
                end
                HOLD: begin
                    tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
                    if (tick) begin
                        if (hold_last) begin
`ifdef PWM_FADE_BREATHE_EN
                            done <= !self_q;
`else
                            done <= 1'b1;
`endif
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && reset;
    assign state_dbg = state;

endmodule
